// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and field widths used by the pipeline-stage registers.
package y86_pkg;

   localparam int STAT_W  = 3;
   localparam int ICODE_W = 4;
   localparam int REGID_W = 4;

   localparam logic [STAT_W-1:0]  STAT_AOK = 3'd1;
   localparam logic [STAT_W-1:0]  STAT_HLT = 3'd2;
   localparam logic [STAT_W-1:0]  STAT_ADR = 3'd3;
   localparam logic [STAT_W-1:0]  STAT_INS = 3'd4;

   localparam logic [ICODE_W-1:0] ICODE_NOP = 4'h1;
   localparam logic [REGID_W-1:0] RNONE     = 4'hF;

endpackage

// File: rtl/y86_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment) and async active-low reset.
module y86_sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != {CNT_W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/y86_pipe_reg.sv
// Y86-64 pipeline-stage register with stall/bubble control, valid tracking and conflict flag.
// Optional stall/bubble cycle counters are compiled in with Y86_PIPE_REG_PERF_EN.
module y86_pipe_reg
   import y86_pkg::*;
#(
   parameter int NUM_REGID = 2,
   parameter int NUM_WORDS = 4,
   parameter int WORD_W    = 64,
   parameter int CNT_W     = 32
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          stall_i,
   input  logic                          bubble_i,
   input  logic [STAT_W-1:0]             in_stat,
   input  logic [ICODE_W-1:0]            in_icode,
   input  logic [3:0]                    in_ifun,
   input  logic [REGID_W*NUM_REGID-1:0]  in_regid,
   input  logic [WORD_W*NUM_WORDS-1:0]   in_words,
   output logic [STAT_W-1:0]             out_stat,
   output logic [ICODE_W-1:0]            out_icode,
   output logic [3:0]                    out_ifun,
   output logic [REGID_W*NUM_REGID-1:0]  out_regid,
   output logic [WORD_W*NUM_WORDS-1:0]   out_words,
   output logic                          out_valid,
   output logic                          conflict_o
`ifdef Y86_PIPE_REG_PERF_EN
   ,
   input  logic                          perf_clr_i,
   output logic [CNT_W-1:0]              stall_cnt_o,
   output logic [CNT_W-1:0]              bubble_cnt_o
`endif
);

   localparam logic [REGID_W*NUM_REGID-1:0] BUBBLE_REGID = {NUM_REGID{RNONE}};

   generate
      if (NUM_REGID < 1 || NUM_WORDS < 1 || WORD_W < 1 || CNT_W < 1) begin : g_bad_params
         $error("y86_pipe_reg: NUM_REGID, NUM_WORDS, WORD_W and CNT_W must all be >= 1");
      end
   endgenerate

   // Stall has priority over bubble; the reset value equals the bubble value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_stat   <= STAT_AOK;
         out_icode  <= ICODE_NOP;
         out_ifun   <= 4'h0;
         out_regid  <= BUBBLE_REGID;
         out_words  <= '0;
         out_valid  <= 1'b0;
         conflict_o <= 1'b0;
      end else begin
         conflict_o <= stall_i & bubble_i;
         if (!stall_i) begin
            if (bubble_i) begin
               out_stat  <= STAT_AOK;
               out_icode <= ICODE_NOP;
               out_ifun  <= 4'h0;
               out_regid <= BUBBLE_REGID;
               out_words <= '0;
               out_valid <= 1'b0;
            end else begin
               out_stat  <= in_stat;
               out_icode <= in_icode;
               out_ifun  <= in_ifun;
               out_regid <= in_regid;
               out_words <= in_words;
               out_valid <= 1'b1;
            end
         end
      end
   end

`ifdef Y86_PIPE_REG_PERF_EN
   // A stall+bubble conflict cycle is counted as a stall only.
   y86_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (stall_i),
      .clr   (perf_clr_i),
      .count (stall_cnt_o)
   );

   y86_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (bubble_i & ~stall_i),
      .clr   (perf_clr_i),
      .count (bubble_cnt_o)
   );
`endif

endmodule

// File: tb/tb_y86_pipe_reg.sv
// Randomized bench for y86_pipe_reg against an array-based reference model.
// Counter checks are active when Y86_PIPE_REG_PERF_EN is defined.
module tb_y86_pipe_reg;

   localparam int NUM_REGID = 2;
   localparam int NUM_WORDS = 4;
   localparam int WORD_W    = 64;
   localparam int CNT_W     = 3;
   localparam int CNT_MAX   = (1 << CNT_W) - 1;

   logic                         clk;
   logic                         rst_n;
   logic                         stall_i;
   logic                         bubble_i;
   logic [2:0]                   in_stat;
   logic [3:0]                   in_icode;
   logic [3:0]                   in_ifun;
   logic [4*NUM_REGID-1:0]       in_regid;
   logic [WORD_W*NUM_WORDS-1:0]  in_words;
   logic [2:0]                   out_stat;
   logic [3:0]                   out_icode;
   logic [3:0]                   out_ifun;
   logic [4*NUM_REGID-1:0]       out_regid;
   logic [WORD_W*NUM_WORDS-1:0]  out_words;
   logic                         out_valid;
   logic                         conflict_o;
   logic                         perf_clr_i;
`ifdef Y86_PIPE_REG_PERF_EN
   logic [CNT_W-1:0]             stall_cnt_o;
   logic [CNT_W-1:0]             bubble_cnt_o;
`endif

   int n_checks;
   int n_errors;

   // Reference model: one entry per field, words and register IDs kept as arrays.
   int          m_stat;
   int          m_icode;
   int          m_ifun;
   logic [3:0]  m_reg [NUM_REGID];
   logic [63:0] m_word [NUM_WORDS];
   int          m_valid;
   int          m_conf;
   int          m_scnt;
   int          m_bcnt;

   y86_pipe_reg #(
      .NUM_REGID (NUM_REGID),
      .NUM_WORDS (NUM_WORDS),
      .WORD_W    (WORD_W),
      .CNT_W     (CNT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .stall_i    (stall_i),
      .bubble_i   (bubble_i),
      .in_stat    (in_stat),
      .in_icode   (in_icode),
      .in_ifun    (in_ifun),
      .in_regid   (in_regid),
      .in_words   (in_words),
      .out_stat   (out_stat),
      .out_icode  (out_icode),
      .out_ifun   (out_ifun),
      .out_regid  (out_regid),
      .out_words  (out_words),
      .out_valid  (out_valid),
      .conflict_o (conflict_o)
`ifdef Y86_PIPE_REG_PERF_EN
      ,
      .perf_clr_i   (perf_clr_i),
      .stall_cnt_o  (stall_cnt_o),
      .bubble_cnt_o (bubble_cnt_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] model_words();
      logic [255:0] r;
      r = '0;
      for (int k = 0; k < NUM_WORDS; k++) r[64*k +: 64] = m_word[k];
      return r;
   endfunction

   function automatic logic [255:0] model_regs();
      logic [255:0] r;
      r = '0;
      for (int k = 0; k < NUM_REGID; k++) r[4*k +: 4] = m_reg[k];
      return r;
   endfunction

   task automatic model_bubble();
      m_stat  = 1;
      m_icode = 1;
      m_ifun  = 0;
      for (int k = 0; k < NUM_REGID; k++) m_reg[k] = 4'hF;
      for (int k = 0; k < NUM_WORDS; k++) m_word[k] = 64'd0;
      m_valid = 0;
   endtask

   task automatic model_reset();
      model_bubble();
      m_conf = 0;
      m_scnt = 0;
      m_bcnt = 0;
   endtask

   // Applies the rules for one clock edge using the inputs currently driven.
   task automatic model_edge();
      if (stall_i) begin
         // contents hold
      end else if (bubble_i) begin
         model_bubble();
      end else begin
         m_stat  = int'(in_stat);
         m_icode = int'(in_icode);
         m_ifun  = int'(in_ifun);
         for (int k = 0; k < NUM_REGID; k++) m_reg[k] = in_regid[4*k +: 4];
         for (int k = 0; k < NUM_WORDS; k++) m_word[k] = in_words[64*k +: 64];
         m_valid = 1;
      end
      m_conf = (stall_i && bubble_i) ? 1 : 0;
      if (perf_clr_i) begin
         m_scnt = 0;
         m_bcnt = 0;
      end else begin
         if (stall_i && m_scnt < CNT_MAX) m_scnt++;
         if (bubble_i && !stall_i && m_bcnt < CNT_MAX) m_bcnt++;
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ".stat"},     256'(out_stat),   256'(m_stat));
      check({tag, ".icode"},    256'(out_icode),  256'(m_icode));
      check({tag, ".ifun"},     256'(out_ifun),   256'(m_ifun));
      check({tag, ".regid"},    256'(out_regid),  model_regs());
      check({tag, ".words"},    256'(out_words),  model_words());
      check({tag, ".valid"},    256'(out_valid),  256'(m_valid));
      check({tag, ".conflict"}, 256'(conflict_o), 256'(m_conf));
`ifdef Y86_PIPE_REG_PERF_EN
      check({tag, ".stall_cnt"},  256'(stall_cnt_o),  256'(m_scnt));
      check({tag, ".bubble_cnt"}, 256'(bubble_cnt_o), 256'(m_bcnt));
`endif
   endtask

   task automatic drive_random_fields();
      in_stat  = 3'($urandom_range(1, 4));
      in_icode = 4'($urandom_range(0, 11));
      in_ifun  = 4'($urandom_range(0, 15));
      in_regid = (4*NUM_REGID)'($urandom);
      for (int k = 0; k < NUM_WORDS; k++) in_words[64*k +: 64] = {$urandom, $urandom};
   endtask

   // Called with clk low: drives control, takes one edge, checks on the falling edge.
   task automatic cycle(input string tag, input logic st, input logic bb, input logic clr);
      stall_i    = st;
      bubble_i   = bb;
      perf_clr_i = clr;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs(tag);
   endtask

   initial begin
      n_checks   = 0;
      n_errors   = 0;
      rst_n      = 1'b0;
      stall_i    = 1'b0;
      bubble_i   = 1'b0;
      perf_clr_i = 1'b0;
      in_stat    = 3'd2;
      in_icode   = 4'd6;
      in_ifun    = 4'd3;
      in_regid   = '0;
      in_words   = '0;
      model_reset();
      repeat (3) @(negedge clk);
      check_outputs("reset");
      rst_n = 1'b1;

      // Normal load of a directed pattern.
      in_stat  = 3'd1;
      in_icode = 4'd6;
      in_ifun  = 4'd2;
      in_regid = 8'h23;
      in_words = {64'h4, 64'h3, 64'h2, 64'h1};
      cycle("load", 1'b0, 1'b0, 1'b0);

      // Three-cycle stall with changing inputs.
      for (int i = 0; i < 3; i++) begin
         drive_random_fields();
         cycle("stall3", 1'b1, 1'b0, 1'b0);
      end

      // Bubble while an instruction is presented.
      in_icode = 4'd7;
      cycle("bubble", 1'b0, 1'b1, 1'b0);

      // Reload, then a stall+bubble conflict followed by a plain cycle.
      drive_random_fields();
      cycle("reload", 1'b0, 1'b0, 1'b0);
      drive_random_fields();
      cycle("conflict", 1'b1, 1'b1, 1'b0);
      drive_random_fields();
      cycle("after_conflict", 1'b0, 1'b0, 1'b0);

      // Long stall drives the stall counter into saturation.
      for (int i = 0; i < 9; i++) begin
         drive_random_fields();
         cycle("stall9", 1'b1, 1'b0, 1'b0);
      end
      cycle("clr_with_stall", 1'b1, 1'b0, 1'b1);
      cycle("after_clr", 1'b0, 1'b1, 1'b0);

      // Randomized mix of loads, stalls, bubbles, conflicts and clears.
      for (int i = 0; i < 400; i++) begin
         drive_random_fields();
         cycle("random", ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 15) == 0));
      end

      // Asynchronous reset between edges, with a stall pending.
      in_icode = 4'd6;
      cycle("pre_rst_load", 1'b0, 1'b0, 1'b0);
      check("pre_rst_icode", 256'(out_icode), 256'(6));
      stall_i  = 1'b1;
      bubble_i = 1'b1;
      @(posedge clk);
      model_edge();
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_outputs("async_rst");
      @(negedge clk);
      check_outputs("rst_held");
      rst_n = 1'b1;
      drive_random_fields();
      cycle("post_rst", 1'b0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
